// File: rtl/ps2_mouse_packet_tracker.sv
// ps2_mouse_packet_tracker
// Assembles standard PS/2 mouse packets from the PS2_Controller byte stream,
// decodes buttons and signed deltas, and keeps a clamped absolute cursor.
// Resynchronises on framing errors (header bit3 clear) and inter-byte timeouts.
// Optional feature: define MOUSE_WHEEL_EN for IntelliMouse 4-byte packets,
// which adds a B3 state and a signed 4-bit wheel output.
// POS_W must be at least 7 so the 9-bit deltas fit the POS_W+2 arithmetic.
module ps2_mouse_packet_tracker #(
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int POS_W          = 10,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [7:0]       received_data,
  input  logic             received_data_en,
  output logic             packet_valid,
  output logic [2:0]       buttons,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
`ifdef MOUSE_WHEEL_EN
  output logic [3:0]       wheel,
`endif
  output logic             sync_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [POS_W+1:0] X_MAX_S = (POS_W+2)'(X_MAX);
  localparam logic signed [POS_W+1:0] Y_MAX_S = (POS_W+2)'(Y_MAX);

`ifdef MOUSE_WHEEL_EN
  typedef enum logic [2:0] {B0, B1, B2, B3, UPD} state_t;
`else
  typedef enum logic [2:0] {B0, B1, B2, UPD} state_t;
`endif

  state_t r_state, w_stateNext;

  // Header stored without the constant bit3: {Yovf, Xovf, Ys, Xs, M, R, L}
  logic [6:0]       r_hdr;
  logic [7:0]       r_xByte;
`ifdef MOUSE_WHEEL_EN
  logic [7:0]       r_yByte;
  logic [3:0]       r_wheel;
  logic             w_latchY;
`endif
  logic [CNT_W-1:0] r_cnt, w_cntNext;

  logic             r_packetValid, r_syncError;
  logic [2:0]       r_buttons;
  logic [8:0]       r_dx, r_dy;
  logic [POS_W-1:0] r_posX, r_posY;

  logic             w_latchHdr, w_latchX, w_fire, w_syncErr, w_isAck, w_timeout;
  logic [7:0]       w_yByte;
  logic [8:0]       w_dx, w_dy;
  logic signed [POS_W+1:0] w_nx, w_ny;
  logic [POS_W-1:0] w_posXNext, w_posYNext;

  // Next-state and strobe handling; UPD treats a coincident strobe as a header byte
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = '0;
    w_latchHdr  = 1'b0;
    w_latchX    = 1'b0;
`ifdef MOUSE_WHEEL_EN
    w_latchY    = 1'b0;
`endif
    w_fire      = 1'b0;
    w_syncErr   = 1'b0;
    w_isAck     = (received_data == 8'hFA) || (received_data == 8'hAA);
    w_timeout   = (r_cnt == TIMEOUT_LAST);
    unique case (r_state)
      B0, UPD: begin
        w_stateNext = B0;
        if (received_data_en && !w_isAck) begin
          if (!received_data[3]) begin
            w_syncErr = 1'b1;
          end else begin
            w_latchHdr  = 1'b1;
            w_stateNext = B1;
          end
        end
      end
      B1: begin
        if (received_data_en) begin
          w_latchX    = 1'b1;
          w_stateNext = B2;
        end else if (w_timeout) begin
          w_syncErr   = 1'b1;
          w_stateNext = B0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      B2: begin
        if (received_data_en) begin
`ifdef MOUSE_WHEEL_EN
          w_latchY    = 1'b1;
          w_stateNext = B3;
`else
          w_fire      = 1'b1;
          w_stateNext = UPD;
`endif
        end else if (w_timeout) begin
          w_syncErr   = 1'b1;
          w_stateNext = B0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
`ifdef MOUSE_WHEEL_EN
      B3: begin
        if (received_data_en) begin
          w_fire      = 1'b1;
          w_stateNext = UPD;
        end else if (w_timeout) begin
          w_syncErr   = 1'b1;
          w_stateNext = B0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
`endif
      default: w_stateNext = B0;
    endcase
  end

  // Delta assembly and clamped position update, evaluated on the final byte
  always_comb begin
`ifdef MOUSE_WHEEL_EN
    w_yByte = r_yByte;
`else
    w_yByte = received_data;
`endif
    w_dx = {r_hdr[3], r_xByte};
    w_dy = {r_hdr[4], w_yByte};
    w_nx = $signed({2'b00, r_posX}) + $signed({{(POS_W-7){w_dx[8]}}, w_dx});
    w_ny = $signed({2'b00, r_posY}) - $signed({{(POS_W-7){w_dy[8]}}, w_dy});
    if (r_hdr[5])           w_posXNext = r_posX;
    else if (w_nx < 0)      w_posXNext = '0;
    else if (w_nx > X_MAX_S) w_posXNext = POS_W'(X_MAX);
    else                    w_posXNext = w_nx[POS_W-1:0];
    if (r_hdr[6])           w_posYNext = r_posY;
    else if (w_ny < 0)      w_posYNext = '0;
    else if (w_ny > Y_MAX_S) w_posYNext = POS_W'(Y_MAX);
    else                    w_posYNext = w_ny[POS_W-1:0];
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= B0;
    else         r_state <= w_stateNext;
  end

  // Inter-byte timeout counter and packet byte latches
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_xByte <= '0;
`ifdef MOUSE_WHEEL_EN
      r_yByte <= '0;
`endif
    end else begin
      r_cnt <= w_cntNext;
      if (w_latchHdr) r_hdr   <= {received_data[7:4], received_data[2:0]};
      if (w_latchX)   r_xByte <= received_data;
`ifdef MOUSE_WHEEL_EN
      if (w_latchY)   r_yByte <= received_data;
`endif
    end
  end

  // Registered outputs: pulses plus decoded packet fields held until the next packet
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_packetValid <= 1'b0;
      r_syncError   <= 1'b0;
      r_buttons     <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_posX        <= POS_W'(X_INIT);
      r_posY        <= POS_W'(Y_INIT);
`ifdef MOUSE_WHEEL_EN
      r_wheel       <= '0;
`endif
    end else begin
      r_packetValid <= w_fire;
      r_syncError   <= w_syncErr;
      if (w_fire) begin
        r_buttons <= r_hdr[2:0];
        r_dx      <= w_dx;
        r_dy      <= w_dy;
        r_posX    <= w_posXNext;
        r_posY    <= w_posYNext;
`ifdef MOUSE_WHEEL_EN
        r_wheel   <= received_data[3:0];
`endif
      end
    end
  end

  assign packet_valid = r_packetValid;
  assign sync_error   = r_syncError;
  assign buttons      = r_buttons;
  assign dx           = r_dx;
  assign dy           = r_dy;
  assign pos_x        = r_posX;
  assign pos_y        = r_posY;
`ifdef MOUSE_WHEEL_EN
  assign wheel        = r_wheel;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet_tracker.sv
// Testbench for ps2_mouse_packet_tracker (default 3-byte build).
// Directed scenarios plus randomized byte streams checked against a
// byte-level behavioural model of packet assembly and cursor clamping.
module tb_ps2_mouse_packet_tracker;

  localparam int TO = 100;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic       packet_valid, sync_error;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic [9:0] pos_x, pos_y;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int         mIdx;
  logic [7:0] mHdr, mX;
  int         ePx, ePy, eDx, eDy;
  logic [2:0] eBtn;
  logic       ePv, eSe;

  ps2_mouse_packet_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .received_data(received_data), .received_data_en(received_data_en),
    .packet_valid(packet_valid), .buttons(buttons), .dx(dx), .dy(dy),
    .pos_x(pos_x), .pos_y(pos_y), .sync_error(sync_error)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  // Watchdog so a stuck run still ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog timeout reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int toDelta(input logic s, input logic [7:0] b);
    return s ? int'(b) - 256 : int'(b);
  endfunction

  task automatic modelReset();
    mIdx = 0; ePx = 320; ePy = 240; eDx = 0; eDy = 0; eBtn = 3'b000; ePv = 1'b0; eSe = 1'b0;
  endtask

  // Byte-level model: each received byte moves the packet position forward
  task automatic modelByte(input logic [7:0] b);
    ePv = 1'b0; eSe = 1'b0;
    if (mIdx == 0) begin
      if (b != 8'hFA && b != 8'hAA) begin
        if (!b[3]) eSe = 1'b1;
        else begin mHdr = b; mIdx = 1; end
      end
    end else if (mIdx == 1) begin
      mX = b; mIdx = 2;
    end else begin
      eDx = toDelta(mHdr[4], mX);
      eDy = toDelta(mHdr[5], b);
      eBtn = mHdr[2:0];
      if (!mHdr[6]) ePx = clampInt(ePx + eDx, 639);
      if (!mHdr[7]) ePy = clampInt(ePy - eDy, 479);
      ePv = 1'b1; mIdx = 0;
    end
  endtask

  // Drives one byte strobe; called and returns at a falling edge
  task automatic applyStimulus(input logic [7:0] b);
    modelByte(b);
    received_data = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
    ePv = 1'b0; eSe = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    modelReset();
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    modelReset();
    #25;
    if (packet_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pv got=%b exp=0", packet_valid); end vectors++;
    if (sync_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_se got=%b exp=0", sync_error); end vectors++;
    if (buttons !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_btn got=%b exp=000", buttons); end vectors++;
    if (dx !== 9'd0 || dy !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_delta got=%0d/%0d exp=0/0", dx, dy); end vectors++;
    if (pos_x !== 10'd320 || pos_y !== 10'd240) begin miscompares++; $display("[TB] FAIL reset_pos got=%0d,%0d exp=320,240", pos_x, pos_y); end vectors++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic test_basic_packet();
    applyReset();
    applyStimulus(8'h08); applyStimulus(8'h0A);
    if (packet_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_pv got=%b exp=0", packet_valid); end vectors++;
    applyStimulus(8'h05);
    if (packet_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_pv got=%b exp=1", packet_valid); end vectors++;
    if (buttons !== 3'b000) begin miscompares++; $display("[TB] FAIL basic_btn got=%b exp=000", buttons); end vectors++;
    if ($signed(dx) != 10 || $signed(dy) != 5) begin miscompares++; $display("[TB] FAIL basic_delta got=%0d/%0d exp=10/5", $signed(dx), $signed(dy)); end vectors++;
    if (pos_x !== 10'd330 || pos_y !== 10'd235) begin miscompares++; $display("[TB] FAIL basic_pos got=%0d,%0d exp=330,235", pos_x, pos_y); end vectors++;
    idleCycles(1);
    if (packet_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_pv_pulse got=%b exp=0", packet_valid); end vectors++;
  endtask

  task automatic test_buttons_negative();
    applyStimulus(8'h19); applyStimulus(8'hF6); applyStimulus(8'h00);
    if (packet_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL neg_pv got=%b exp=1", packet_valid); end vectors++;
    if (buttons !== 3'b001) begin miscompares++; $display("[TB] FAIL neg_btn got=%b exp=001", buttons); end vectors++;
    if ($signed(dx) != -10 || $signed(dy) != 0) begin miscompares++; $display("[TB] FAIL neg_delta got=%0d/%0d exp=-10/0", $signed(dx), $signed(dy)); end vectors++;
    if (pos_x !== 10'd320 || pos_y !== 10'd235) begin miscompares++; $display("[TB] FAIL neg_pos got=%0d,%0d exp=320,235", pos_x, pos_y); end vectors++;
  endtask

  task automatic test_framing();
    applyReset();
    applyStimulus(8'hFA);
    if (sync_error !== 1'b0 || packet_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_ack got=se%b pv%b exp=se0 pv0", sync_error, packet_valid); end vectors++;
    applyStimulus(8'h02);
    if (sync_error !== 1'b1) begin miscompares++; $display("[TB] FAIL frame_err got=%b exp=1", sync_error); end vectors++;
    applyStimulus(8'h08);
    if (sync_error !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_err_pulse got=%b exp=0", sync_error); end vectors++;
    applyStimulus(8'h01); applyStimulus(8'h01);
    if (packet_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL frame_pv got=%b exp=1", packet_valid); end vectors++;
    if ($signed(dx) != 1 || $signed(dy) != 1) begin miscompares++; $display("[TB] FAIL frame_delta got=%0d/%0d exp=1/1", $signed(dx), $signed(dy)); end vectors++;
    if (pos_x !== 10'd321 || pos_y !== 10'd239) begin miscompares++; $display("[TB] FAIL frame_pos got=%0d,%0d exp=321,239", pos_x, pos_y); end vectors++;
  endtask

  task automatic test_saturation();
    int ex, ey;
    applyReset();
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(8'h08); applyStimulus(8'hFF); applyStimulus(8'h00);
      ex = (320 + 255 * n > 639) ? 639 : 320 + 255 * n;
      if (int'(pos_x) != ex || $signed(dx) != 255) begin miscompares++; $display("[TB] FAIL satx_%0d got=%0d dx=%0d exp=%0d dx=255", n, pos_x, $signed(dx), ex); end vectors++;
    end
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(8'h38); applyStimulus(8'h00); applyStimulus(8'h80);
      ey = (240 + 128 * n > 479) ? 479 : 240 + 128 * n;
      ex = (639 - 256 * n < 0) ? 0 : 639 - 256 * n;
      if (int'(pos_y) != ey || $signed(dy) != -128) begin miscompares++; $display("[TB] FAIL saty_%0d got=%0d dy=%0d exp=%0d dy=-128", n, pos_y, $signed(dy), ey); end vectors++;
      if (int'(pos_x) != ex) begin miscompares++; $display("[TB] FAIL satx0_%0d got=%0d exp=%0d", n, pos_x, ex); end vectors++;
    end
  endtask

  task automatic test_timeout();
    int seen, at;
    logic pvSeen;
    applyReset();
    applyStimulus(8'h08); applyStimulus(8'h05);
    seen = 0; at = -1; pvSeen = 1'b0;
    for (int i = 1; i <= TO + 20; i++) begin
      @(negedge CLOCK_50);
      if (packet_valid) pvSeen = 1'b1;
      if (sync_error) begin seen++; if (at < 0) at = i; end
    end
    mIdx = 0; ePv = 1'b0; eSe = 1'b0;
    if (seen != 1) begin miscompares++; $display("[TB] FAIL tmo_count got=%0d exp=1", seen); end vectors++;
    if (at < TO - 1 || at > TO + 1) begin miscompares++; $display("[TB] FAIL tmo_cycle got=%0d exp=%0d", at, TO); end vectors++;
    if (pvSeen !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_pv got=%b exp=0", pvSeen); end vectors++;
    if (pos_x !== 10'd320 || dx !== 9'd0) begin miscompares++; $display("[TB] FAIL tmo_hold got=%0d/%0d exp=320/0", pos_x, dx); end vectors++;
    applyStimulus(8'h08); applyStimulus(8'h01); applyStimulus(8'h01);
    if (packet_valid !== 1'b1 || $signed(dx) != 1 || $signed(dy) != 1) begin miscompares++; $display("[TB] FAIL tmo_next got=pv%b %0d/%0d exp=pv1 1/1", packet_valid, $signed(dx), $signed(dy)); end vectors++;
    if (pos_x !== 10'd321 || pos_y !== 10'd239) begin miscompares++; $display("[TB] FAIL tmo_pos got=%0d,%0d exp=321,239", pos_x, pos_y); end vectors++;
  endtask

  task automatic test_overflow();
    applyReset();
    applyStimulus(8'h48); applyStimulus(8'h10); applyStimulus(8'h00);
    if (packet_valid !== 1'b1 || $signed(dx) != 16) begin miscompares++; $display("[TB] FAIL xovf_dx got=pv%b %0d exp=pv1 16", packet_valid, $signed(dx)); end vectors++;
    if (pos_x !== 10'd320 || pos_y !== 10'd240) begin miscompares++; $display("[TB] FAIL xovf_pos got=%0d,%0d exp=320,240", pos_x, pos_y); end vectors++;
    applyStimulus(8'h88); applyStimulus(8'h04); applyStimulus(8'h7F);
    if ($signed(dy) != 127 || pos_y !== 10'd240 || pos_x !== 10'd324) begin miscompares++; $display("[TB] FAIL yovf got=dy%0d %0d,%0d exp=dy127 324,240", $signed(dy), pos_x, pos_y); end vectors++;
  endtask

  task automatic test_reset_mid_packet();
    applyStimulus(8'h0F); applyStimulus(8'h03); applyStimulus(8'h03);
    if (buttons !== 3'b111) begin miscompares++; $display("[TB] FAIL mid_pre_btn got=%b exp=111", buttons); end vectors++;
    applyStimulus(8'h08);
    resetn = 1'b0;
    #1;
    if (buttons !== 3'b000 || dx !== 9'd0 || dy !== 9'd0) begin miscompares++; $display("[TB] FAIL mid_rst_fields got=%b %0d/%0d exp=000 0/0", buttons, dx, dy); end vectors++;
    if (pos_x !== 10'd320 || pos_y !== 10'd240) begin miscompares++; $display("[TB] FAIL mid_rst_pos got=%0d,%0d exp=320,240", pos_x, pos_y); end vectors++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    modelReset();
    applyStimulus(8'h08); applyStimulus(8'h01); applyStimulus(8'h01);
    if (packet_valid !== 1'b1 || pos_x !== 10'd321 || pos_y !== 10'd239) begin miscompares++; $display("[TB] FAIL mid_next got=pv%b %0d,%0d exp=pv1 321,239", packet_valid, pos_x, pos_y); end vectors++;
  endtask

  // Random packets, maxGap=0 gives fully back-to-back strobes including during UPD
  task automatic test_random_stream(input int n, input int maxGap);
    logic [7:0] b;
    int r;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < 3; k++) begin
        if (k == 0) begin
          r = $urandom_range(0, 15);
          if (r == 0) b = 8'($urandom);
          else b = (8'($urandom) & 8'h37) | 8'h08 | ((r == 1) ? 8'h40 : 8'h00) | ((r == 2) ? 8'h80 : 8'h00);
        end else begin
          b = 8'($urandom);
        end
        applyStimulus(b);
        if (packet_valid !== ePv) begin miscompares++; $display("[TB] FAIL rnd_pv p=%0d k=%0d got=%b exp=%b", p, k, packet_valid, ePv); end vectors++;
        if (sync_error !== eSe) begin miscompares++; $display("[TB] FAIL rnd_se p=%0d k=%0d got=%b exp=%b", p, k, sync_error, eSe); end vectors++;
        if (buttons !== eBtn) begin miscompares++; $display("[TB] FAIL rnd_btn p=%0d got=%b exp=%b", p, buttons, eBtn); end vectors++;
        if ($signed(dx) != eDx || $signed(dy) != eDy) begin miscompares++; $display("[TB] FAIL rnd_delta p=%0d got=%0d/%0d exp=%0d/%0d", p, $signed(dx), $signed(dy), eDx, eDy); end vectors++;
        if (int'(pos_x) != ePx || int'(pos_y) != ePy) begin miscompares++; $display("[TB] FAIL rnd_pos p=%0d got=%0d,%0d exp=%0d,%0d", p, pos_x, pos_y, ePx, ePy); end vectors++;
        if (maxGap > 0) idleCycles($urandom_range(0, maxGap));
      end
    end
  endtask

  initial begin
    $display("[TB] starting ps2_mouse_packet_tracker bench");
    test_reset();
    test_basic_packet();
    test_buttons_negative();
    test_framing();
    test_saturation();
    test_timeout();
    test_overflow();
    test_reset_mid_packet();
    applyReset();
    test_random_stream(40, 0);
    test_random_stream(300, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_tracker.md
Name: ps2_mouse_packet_tracker

Overview:
- Successor to the raw-byte mouse path: consumes the byte stream from PS2_Controller (received_data / received_data_en) and assembles standard PS/2 mouse packets.
- Decodes buttons and signed deltas, and maintains a clamped absolute cursor position for the screen.
- Resynchronises on framing errors and inter-byte timeouts.
- Sits between PS2_Controller and game/VGA logic, replacing the last-byte-to-HEX debug path.

Parameters:
- X_MAX, 639, maximum cursor X (inclusive); minimum is 0.
- Y_MAX, 479, maximum cursor Y (inclusive); minimum is 0.
- POS_W, 10, width of pos_x/pos_y; must hold X_MAX and Y_MAX.
- X_INIT, 320, cursor X after reset.
- Y_INIT, 240, cursor Y after reset.
- TIMEOUT_CYCLES, 1000000, max clocks between bytes of one packet (20 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- received_data  input  8  byte from PS2_Controller.
- received_data_en  input  1  one-cycle strobe; received_data is valid this cycle.
- packet_valid  output  1  one-cycle pulse; a complete packet was decoded.
- buttons  output  3  {middle, right, left} from the last packet.
- dx  output  9  signed X delta from the last packet.
- dy  output  9  signed Y delta from the last packet (PS/2 sense: positive = up).
- pos_x  output  POS_W  clamped cursor X.
- pos_y  output  POS_W  clamped cursor Y (0 = top).
- sync_error  output  1  one-cycle pulse on a discarded byte/packet due to framing or timeout.

Behaviour:
- Reset (async, resetn=0):
  - State is B0.
  - packet_valid=0, sync_error=0, buttons=0, dx=0, dy=0.
  - pos_x=X_INIT, pos_y=Y_INIT.
  - Timeout counter = 0.
- FSM states:
  - B0 (wait header): on strobe:
    - 0xFA or 0xAA: silently ignored, no error. These are ack/self-test bytes; a genuine header of 0xFA is sacrificed.
    - Bit3 = 0: discard, pulse sync_error, stay in B0.
    - Otherwise: latch header and go to B1.
  - B1: on strobe, latch X byte and go to B2.
  - B2: on strobe, latch Y byte and go to UPD (or B3 with the optional feature).
  - UPD: single cycle; update outputs, then return to B0. Any strobe arriving during UPD is taken as a B0 byte.
- Header bit map: [7]=Yovf, [6]=Xovf, [5]=Ys, [4]=Xs, [3]=1, [2]=M, [1]=R, [0]=L.
- Deltas:
  - dx = {Xs, byte1}.
  - dy = {Ys, byte2}.
  - Both are 9-bit two's complement, range -256..+255.
- Outputs in UPD, registered:
  - packet_valid is high for exactly the UPD cycle.
  - buttons, dx, dy and positions become visible in that same cycle.
  - Latency: packet_valid rises 1 clock after the final byte's strobe cycle.
- Position arithmetic (signed, POS_W+2 bits):
  - nx = pos_x + dx; ny = pos_y - dy (screen Y grows downward).
  - Clamp each to [0, MAX]: results < 0 become 0; results > MAX become MAX.
- Overflow:
  - Xovf=1: pos_x is unchanged that packet.
  - Yovf=1: pos_y is unchanged that packet.
  - dx/dy still report raw values.
- Timeout:
  - Counter clears on every accepted strobe and counts while in B1/B2 (B3).
  - On reaching TIMEOUT_CYCLES: go to B0, pulse sync_error, discard the partial packet. Outputs hold their previous values.
- Simultaneous strobe and timeout in the same cycle: the strobe wins and the counter clears.
- Counter does not run in B0.
- Reset mid-packet: partial data is discarded and all outputs return to reset values.

Optional Feature:
- MOUSE_WHEEL_EN defined:
  - FSM includes B3 between B2 and UPD for the IntelliMouse 4-byte packet.
  - Adds output port wheel (4-bit signed, from byte3[3:0]), reset 0, updated in UPD.
  - Timeout also applies in B3.
- Undefined:
  - 3-byte packets only, no wheel port, B3 does not exist.

Test Plan:
- Reset, then bytes 0x08, 0x0A, 0x05 -> packet_valid pulse 1 clk after the 3rd strobe; buttons=0, dx=+10, dy=+5, pos_x=330, pos_y=235.
- Bytes 0x19, 0xF6, 0x00 -> buttons=3'b001, dx=-10, pos_x decreases by 10, pos_y unchanged.
- Stream 0xFA, 0x02, 0x08, 0x01, 0x01 -> 0xFA ignored silently; 0x02 gives a sync_error pulse; then one valid packet with dx=+1, dy=+1.
- Repeated 0x08, 0xFF, 0x00 (dx=+255) from 320 -> pos_x saturates at 639 and stays 639. Repeated 0x38, 0x00, 0x80 (dy=-128) -> pos_y saturates at 479.
- Bytes 0x08, 0x05, then silence for TIMEOUT_CYCLES (overridden to 100 in bench) -> sync_error pulse at cycle 100, no packet_valid. Next 0x08, 0x01, 0x01 decodes correctly.
- Header 0x48 with X byte 0x10 -> pos_x unchanged, dx=+16 reported. Assert resetn low between bytes 1 and 2 -> outputs return to reset values immediately.
